led_fader: RTL

Downstream stage for the rotating LED pattern generator. It takes the generator's 8-bit pattern and drives the physical LEDs through per-channel 4-bit brightness levels and PWM. Lit bits ramp up and cleared bits decay, so a shifting pattern leaves a fading trail. It sits between the pattern generator's `leds` output and the board LED pins.

---
 rtl/led_fader.sv | 69 ++++++
 1 files changed

// File: rtl/led_fader.sv
// Per-channel LED fader: 8-bit pattern -> 4-bit brightness levels -> 15-step PWM drive.
// Lit pattern bits ramp up, cleared bits decay, leaving a fading trail behind a moving pattern.
module led_fader #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int FADE_HZ   = 64,
  parameter int RISE_STEP = 15,
  parameter int FALL_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pattern_in,
  input  logic       fade_en,
  output logic [7:0] leds,
  output logic       fade_tick
);

  localparam int FADE_DIV = CLK_FREQ / FADE_HZ;
  localparam int CW       = $clog2(FADE_DIV);
  localparam logic [CW-1:0] FADE_LAST = CW'(FADE_DIV - 1);
  localparam logic [3:0]    PWM_LAST  = 4'd14;

  logic [CW-1:0] fade_cnt;
  logic [3:0]    pwm_cnt;
  logic [3:0]    level     [8];
  logic [3:0]    level_nxt [8];
  logic          tick_edge;

  // Saturating step: widened to 5 bits so neither direction can wrap.
  function automatic logic [3:0] faded(input logic [3:0] lvl, input logic lit);
    logic [4:0]        up;
    logic signed [4:0] down;
    up   = {1'b0, lvl} + 5'(RISE_STEP);
    down = $signed({1'b0, lvl}) - $signed(5'(FALL_STEP));
    if (lit) faded = (up > 5'd15) ? 4'd15 : up[3:0];
    else     faded = (down < 0) ? 4'd0 : down[3:0];
  endfunction

  assign tick_edge = (fade_cnt == FADE_LAST);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_nxt[i] = level[i];
      if (!fade_en)       level_nxt[i] = {4{pattern_in[i]}};
      else if (tick_edge) level_nxt[i] = faded(level[i], pattern_in[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fade_cnt  <= '0;
      pwm_cnt   <= '0;
      leds      <= '0;
      fade_tick <= 1'b0;
      // NOTE: the level array is eight small flops, not a RAM, so it is cleared by reset like any register.
      for (int i = 0; i < 8; i++) level[i] <= '0;
    end else begin
      fade_cnt  <= tick_edge ? '0 : fade_cnt + 1'b1;
      fade_tick <= tick_edge;
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? 4'd0 : pwm_cnt + 4'd1;
      for (int i = 0; i < 8; i++) begin
        leds[i]  <= (level[i] > pwm_cnt);
        level[i] <= level_nxt[i];
      end
    end
  end

endmodule
